// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request/ack handshake and the IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_valid,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
);

    // Handshake: a fetch completes on any rising edge where imem_req and imem_ack are both 1;
    // imem_addr stays put while imem_req is high and no ack has arrived.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_addr;
    logic [INSTR_W-1:0]   r_hold;
    logic [ADDR_W-1:0]    r_if_pc;
    logic [INSTR_W-1:0]   r_if_instr;
    logic                 r_if_valid;

    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic [ADDR_W-1:0]    w_pc_inc;
    logic [ADDR_W-1:0]    w_addr_nxt;
    logic                 w_hold_load;
    logic                 w_if_load;
    logic [ADDR_W-1:0]    w_if_pc_nxt;
    logic [INSTR_W-1:0]   w_if_instr_nxt;
    logic                 w_if_valid_nxt;

    assign w_pc_inc = r_pc + ADDR_W'(PC_STEP);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_hold_load    = 1'b0;
        w_if_load      = 1'b0;
        w_if_pc_nxt    = r_pc;
        w_if_instr_nxt = '0;
        w_if_valid_nxt = 1'b0;

        if (branch_taken) begin
            // Redirect wins over freeze; an unacked request must still be drained.
            w_pc_nxt  = branch_target;
            w_if_load = 1'b1;
            case (r_state)
                S_REQ:   w_state_nxt = imem_ack ? S_REQ : S_DRAIN;
                S_HOLD:  w_state_nxt = S_REQ;
                S_DRAIN: w_state_nxt = imem_ack ? S_REQ : S_DRAIN;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ack && !freeze) begin
                        w_if_load      = 1'b1;
                        w_if_instr_nxt = imem_rdata;
                        w_if_valid_nxt = 1'b1;
                        w_pc_nxt       = w_pc_inc;
                    end else if (imem_ack && freeze) begin
                        w_hold_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else if (!freeze) begin
                        w_if_load = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        w_if_load      = 1'b1;
                        w_if_instr_nxt = r_hold;
                        w_if_valid_nxt = 1'b1;
                        w_pc_nxt       = w_pc_inc;
                        w_state_nxt    = S_REQ;
                    end
                end
                S_DRAIN: begin
                    w_if_load = 1'b1;
                    if (imem_ack) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // While draining, the stale address must stay on the bus until it is acked.
    assign w_addr_nxt = (w_state_nxt == S_DRAIN) ? r_addr : w_pc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_hold     <= '0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
            r_if_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            if (w_hold_load) begin
                r_hold <= imem_rdata;
            end
            if (w_if_load) begin
                r_if_pc    <= w_if_pc_nxt;
                r_if_instr <= w_if_instr_nxt;
                r_if_valid <= w_if_valid_nxt;
            end
        end
    end

    assign imem_req  = !rst && (r_state != S_HOLD);
    assign imem_addr = r_addr;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign if_valid  = r_if_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = freeze || (r_state == S_DRAIN) || ((r_state == S_REQ) && !imem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_if_load && w_if_valid_nxt) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table followed by randomized traffic against a
// transaction-level fetch model (pending instruction slot + stale-request flag).
module tb_if_stage;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          freeze = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b1;
    logic [IW-1:0] imem_rdata;
    logic [AW-1:0] if_pc;
    logic [IW-1:0] if_instr;
    logic          if_valid;
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_stall_cnt;
    bit            scramble = 1'b0;

    always #5 clk = ~clk;

    if_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc(if_pc), .if_instr(if_instr),
        .if_valid(if_valid), .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input bit scr);
        if (!scr) return a;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    always_comb imem_rdata = mem_rd(imem_addr, scramble);

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // mask bits: 0 addr, 1 valid+instr, 2 pc, 3 counters are zero
    typedef struct {
        logic        rst, frz, ack, br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        logic [3:0]  mask;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, f, a, b, input logic [31:0] t, input logic q,
                       input logic [31:0] ad, input logic v, input logic [31:0] p, i,
                       input logic [3:0] m);
        vec_t x;
        x.rst = r; x.frz = f; x.ack = a; x.br = b; x.tgt = t;
        x.e_req = q; x.e_addr = ad; x.e_valid = v; x.e_pc = p; x.e_instr = i; x.mask = m;
        vt.push_back(x);
    endtask

    // Reference model state
    logic [31:0] m_pc, m_hold, m_stale_addr, m_if_pc, m_if_instr, m_fc, m_sc;
    bit          m_hold_v, m_stale, m_if_v;

    task automatic model_reset();
        m_pc = '0; m_hold = '0; m_stale_addr = '0; m_hold_v = 0; m_stale = 0;
        m_if_pc = '0; m_if_instr = '0; m_if_v = 0; m_fc = '0; m_sc = '0;
    endtask

    task automatic model_step(input bit r, f, a, b, input logic [31:0] t, input logic [31:0] rd);
        if (r) begin
            model_reset();
            return;
        end
        if (f || m_stale || (!m_hold_v && !a)) m_sc++;
        if (b) begin
            if (m_stale) begin
                if (a) m_stale = 0;
            end else if (!m_hold_v && !a) begin
                m_stale = 1;
                m_stale_addr = m_pc;
            end
            m_hold_v = 0;
            m_if_v = 0; m_if_instr = '0;
            m_pc = t;
        end else if (m_stale) begin
            m_if_v = 0; m_if_instr = '0; m_if_pc = m_pc;
            if (a) m_stale = 0;
        end else if (m_hold_v) begin
            if (!f) begin
                m_if_pc = m_pc; m_if_instr = m_hold; m_if_v = 1; m_fc++;
                m_pc = m_pc + 32'd4;
                m_hold_v = 0;
            end
        end else if (a && !f) begin
            m_if_pc = m_pc; m_if_instr = rd; m_if_v = 1; m_fc++;
            m_pc = m_pc + 32'd4;
        end else if (a && f) begin
            m_hold = rd; m_hold_v = 1;
        end else if (!f) begin
            m_if_v = 0; m_if_instr = '0; m_if_pc = m_pc;
        end
    endtask

    initial begin
        //   rst frz ack br tgt            req addr          v  pc            instr         mask
        add(1, 0, 1, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        4'b0000);
        add(1, 0, 1, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        4'b1111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h4,        1, 32'h0,        32'h0,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h8,        1, 32'h4,        32'h4,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'hC,        1, 32'h8,        32'h8,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h10,       1, 32'hC,        32'hC,        4'b0111);
        // ack stall on 0x8
        add(1, 0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h10,       32'h10,       4'b0110);
        add(0, 0, 1, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        4'b1111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h4,        1, 32'h0,        32'h0,        4'b0111);
        add(0, 0, 0, 0, 32'h0,         1, 32'h8,        1, 32'h4,        32'h4,        4'b0111);
        add(0, 0, 0, 0, 32'h0,         1, 32'h8,        0, 32'h8,        32'h0,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h8,        0, 32'h8,        32'h0,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'hC,        1, 32'h8,        32'h8,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h10,       1, 32'hC,        32'hC,        4'b0111);
        // freeze for 3 cycles while 0x8 is fetched
        add(1, 0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h10,       32'h10,       4'b0110);
        add(0, 0, 1, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h4,        1, 32'h0,        32'h0,        4'b0111);
        add(0, 1, 1, 0, 32'h0,         1, 32'h8,        1, 32'h4,        32'h4,        4'b0111);
        add(0, 1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4,        32'h4,        4'b0110);
        add(0, 1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4,        32'h4,        4'b0110);
        add(0, 0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4,        32'h4,        4'b0110);
        add(0, 0, 1, 0, 32'h0,         1, 32'hC,        1, 32'h8,        32'h8,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h10,       1, 32'hC,        32'hC,        4'b0111);
        // branch under freeze
        add(0, 1, 1, 1, 32'h40,        1, 32'h14,       1, 32'h10,       32'h10,       4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h40,       0, 32'h0,        32'h0,        4'b0011);
        add(0, 0, 1, 0, 32'h0,         1, 32'h44,       1, 32'h40,       32'h40,       4'b0111);
        // branch with an outstanding request to 0x10
        add(1, 0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h44,       32'h44,       4'b0110);
        add(0, 0, 1, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h4,        1, 32'h0,        32'h0,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h8,        1, 32'h4,        32'h4,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'hC,        1, 32'h8,        32'h8,        4'b0111);
        add(0, 0, 0, 1, 32'h80,        1, 32'h10,       1, 32'hC,        32'hC,        4'b0111);
        add(0, 0, 0, 0, 32'h0,         1, 32'h10,       0, 32'h0,        32'h0,        4'b0011);
        add(0, 0, 1, 0, 32'h0,         1, 32'h10,       0, 32'h0,        32'h0,        4'b0011);
        add(0, 0, 1, 0, 32'h0,         1, 32'h80,       0, 32'h0,        32'h0,        4'b0011);
        add(0, 0, 1, 0, 32'h0,         1, 32'h84,       1, 32'h80,       32'h80,       4'b0111);
        // reset while holding a fetched instruction
        add(0, 1, 1, 0, 32'h0,         1, 32'h88,       1, 32'h84,       32'h84,       4'b0111);
        add(1, 1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h84,       32'h84,       4'b0110);
        add(0, 0, 1, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        4'b1111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h4,        1, 32'h0,        32'h0,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h8,        1, 32'h4,        32'h4,        4'b0111);
        // PC wrap at the top of the address space
        add(0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'hC,        1, 32'h8,        32'h8,        4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,       32'h0,        4'b0011);
        add(0, 0, 1, 0, 32'h0,         1, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 4'b0111);
        add(0, 0, 1, 0, 32'h0,         1, 32'h4,        1, 32'h0,        32'h0,        4'b0111);

        foreach (vt[k]) begin
            @(negedge clk);
            rst = vt[k].rst; freeze = vt[k].frz; imem_ack = vt[k].ack;
            branch_taken = vt[k].br; branch_target = vt[k].tgt;
            #1;
            chk($sformatf("v%0d.req", k), 32'(imem_req), 32'(vt[k].e_req));
            if (vt[k].mask[0]) chk($sformatf("v%0d.addr", k), imem_addr, vt[k].e_addr);
            if (vt[k].mask[1]) begin
                chk($sformatf("v%0d.valid", k), 32'(if_valid), 32'(vt[k].e_valid));
                chk($sformatf("v%0d.instr", k), if_instr, vt[k].e_instr);
            end
            if (vt[k].mask[2]) chk($sformatf("v%0d.pc", k), if_pc, vt[k].e_pc);
            if (vt[k].mask[3]) begin
                chk($sformatf("v%0d.fcnt0", k), perf_fetch_cnt, 32'h0);
                chk($sformatf("v%0d.scnt0", k), perf_stall_cnt, 32'h0);
            end
        end

        // Randomized traffic against the model
        scramble = 1'b1;
        repeat (2) begin
            @(negedge clk);
            rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        end
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic e_req;
            @(negedge clk);
            rst           = ($urandom_range(0, 299) == 0);
            freeze        = ($urandom_range(0, 99) < 30);
            imem_ack      = ($urandom_range(0, 99) < 60);
            branch_taken  = ($urandom_range(0, 99) < 8);
            branch_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8
                                                        : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            #1;
            e_req = !rst && !m_hold_v;
            chk("rnd.req", 32'(imem_req), 32'(e_req));
            if (e_req) chk("rnd.addr", imem_addr, m_stale ? m_stale_addr : m_pc);
            chk("rnd.valid", 32'(if_valid), 32'(m_if_v));
            if (m_if_v) begin
                chk("rnd.pc", if_pc, m_if_pc);
                chk("rnd.instr", if_instr, m_if_instr);
            end else begin
                chk("rnd.nop", if_instr, 32'h0);
            end
`ifdef IF_PERF_CNT_EN
            chk("rnd.fcnt", perf_fetch_cnt, m_fc);
            chk("rnd.scnt", perf_stall_cnt, m_sc);
`else
            chk("rnd.fcnt", perf_fetch_cnt, 32'h0);
            chk("rnd.scnt", perf_stall_cnt, 32'h0);
`endif
            model_step(rst, freeze, imem_ack && e_req, branch_taken, branch_target,
                       mem_rd(m_stale ? m_stale_addr : m_pc, 1'b1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
